// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: ALU op codes, FSM state type,
// default widths and a small one-hot helper.
package alu_arbiter_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned CTRLW_DEF = 3;
    localparam int unsigned NREQ      = 2;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    // Requester index to one-hot request/response vector.
    function automatic logic [NREQ-1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the ALU arbiter: request handshake with operands and
// the held response handshake.
//  master : requester side (drives requests, consumes responses)
//  slave  : arbiter side
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CTRLW = 3
);
    logic [1:0]            ReqValid;
    logic [1:0]            ReqReady;
    logic [1:0][WIDTH-1:0] ReqSrcA;
    logic [1:0][WIDTH-1:0] ReqSrcB;
    logic [1:0][CTRLW-1:0] ReqCtrl;
    logic [1:0]            RespValid;
    logic [1:0]            RespReady;
    logic [WIDTH-1:0]      RespResult;
    logic                  RespZero;

    modport master (
        output ReqValid, ReqSrcA, ReqSrcB, ReqCtrl, RespReady,
        input  ReqReady, RespValid, RespResult, RespZero
    );

    modport slave (
        input  ReqValid, ReqSrcA, ReqSrcB, ReqCtrl, RespReady,
        output ReqReady, RespValid, RespResult, RespZero
    );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin arbiter.
//  req_valid  : per-requester request
//  last_grant : index granted on the previous accept
//  grant      : one-hot grant (zero when nothing requests)
//  grant_idx  : index of the granted requester
module rr_arb2
    import alu_arbiter_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_idx
);

    always_comb begin
        grant_idx = 1'b0;
        grant     = 2'b00;
        case (req_valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            // Contention: whoever was not served last time goes first.
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
        if (|req_valid) begin
            grant = idx_to_onehot(grant_idx);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters. A granted request's
// operands are registered onto the ALU inputs, the ALU result is captured one
// cycle later and held under a valid/ready response handshake to its owner.
//  clk, reset_n          : clock, asynchronous active-low reset
//  bus (slave)           : request/response handshakes of both requesters
//  SrcA/SrcB/ALUControl  : registered operands/op to the ALU
//  ALUResult/Zero        : ALU outputs
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CTRLW = CTRLW_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_arbiter_if.slave     bus,
    output logic [WIDTH-1:0] SrcA,
    output logic [WIDTH-1:0] SrcB,
    output logic [CTRLW-1:0] ALUControl,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             Zero
);

    arb_state_t       state_q,      state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q,      owner_d;
    logic [WIDTH-1:0] src_a_q,      src_a_d;
    logic [WIDTH-1:0] src_b_q,      src_b_d;
    logic [CTRLW-1:0] ctrl_q,       ctrl_d;
    logic [WIDTH-1:0] result_q,     result_d;
    logic             zero_q,       zero_d;
    logic [1:0]       resp_valid_q, resp_valid_d;

    logic [1:0]       grant;
    logic             grant_idx;

    rr_arb2 u_rr_arb2 (
        .req_valid  (bus.ReqValid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Next-state and datapath register updates.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        ctrl_d       = ctrl_q;
        result_d     = result_q;
        zero_d       = zero_q;
        resp_valid_d = resp_valid_q;

        case (state_q)
            ARB_IDLE: begin
                if (|grant) begin
                    src_a_d      = bus.ReqSrcA[grant_idx];
                    src_b_d      = bus.ReqSrcB[grant_idx];
                    ctrl_d       = bus.ReqCtrl[grant_idx];
                    owner_d      = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                result_d     = ALUResult;
                zero_d       = Zero;
                resp_valid_d = idx_to_onehot(owner_q);
                state_d      = ARB_RESP;
            end
            ARB_RESP: begin
                // Only the owner's ready can retire the response.
                if (bus.RespReady[owner_q]) begin
                    resp_valid_d = 2'b00;
                    state_d      = ARB_IDLE;
                end
            end
            default: begin
                resp_valid_d = 2'b00;
                state_d      = ARB_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            src_a_q      <= '0;
            src_b_q      <= '0;
            ctrl_q       <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            resp_valid_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            ctrl_q       <= ctrl_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Accept is combinational in IDLE; held low while reset is applied.
    assign bus.ReqReady   = (reset_n && (state_q == ARB_IDLE)) ? grant : 2'b00;
    assign bus.RespValid  = resp_valid_q;
    assign bus.RespResult = result_q;
    assign bus.RespZero   = zero_q;
    assign SrcA           = src_a_q;
    assign SrcB           = src_b_q;
    assign ALUControl     = ctrl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 3;

    logic          clk;
    logic          reset_n;
    logic [W-1:0]  SrcA;
    logic [W-1:0]  SrcB;
    logic [CW-1:0] ALUControl;
    logic [W-1:0]  ALUResult;
    logic          Zero;

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter_if #(.WIDTH(W), .CTRLW(CW)) bus ();

    alu_arbiter #(.WIDTH(W), .CTRLW(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .ALUResult  (ALUResult),
        .Zero       (Zero)
    );

    // Behavioural ALU the arbiter drives.
    always_comb begin
        case (ALUControl)
            ALU_ADD:  ALUResult = SrcA + SrcB;
            ALU_SUB:  ALUResult = SrcA - SrcB;
            ALU_AND:  ALUResult = SrcA & SrcB;
            ALU_OR:   ALUResult = SrcA | SrcB;
            ALU_PASS: ALUResult = SrcB;
            ALU_SLT:  ALUResult = ($signed(SrcA) < $signed(SrcB)) ? 32'd1 : 32'd0;
            default:  ALUResult = 32'd0;
        endcase
        Zero = (ALUResult == 32'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        bus.ReqSrcA[idx] = a;
        bus.ReqSrcB[idx] = b;
        bus.ReqCtrl[idx] = op;
    endtask

    // One uncontended request through to its retired response.
    task automatic run_single(input string tag, input logic idx, input logic [31:0] a,
                              input logic [31:0] b, input logic [2:0] op,
                              input logic [31:0] exp_res, input logic exp_zero);
        logic [1:0] oh;
        oh = idx_to_onehot(idx);
        set_req(idx, a, b, op);
        bus.ReqValid = oh;
        #1;
        chk({tag, "_rdy"}, 32'(bus.ReqReady), 32'(oh));
        tick();
        bus.ReqValid = 2'b00;
        chk({tag, "_exec_rdy"}, 32'(bus.ReqReady), 32'd0);
        chk({tag, "_exec_vld"}, 32'(bus.RespValid), 32'd0);
        chk({tag, "_srca"}, SrcA, a);
        chk({tag, "_ctrl"}, 32'(ALUControl), 32'(op));
        tick();
        chk({tag, "_vld"}, 32'(bus.RespValid), 32'(oh));
        chk({tag, "_res"}, bus.RespResult, exp_res);
        chk({tag, "_zero"}, 32'(bus.RespZero), 32'(exp_zero));
        bus.RespReady = oh;
        tick();
        bus.RespReady = 2'b00;
        chk({tag, "_done"}, 32'(bus.RespValid), 32'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.ReqValid  = 2'b11;
        bus.RespReady = 2'b00;
        bus.ReqSrcA   = '0;
        bus.ReqSrcB   = '0;
        bus.ReqCtrl   = '0;

        // Reset values, even with both requesters asking.
        #3;
        chk("rst_rdy",  32'(bus.ReqReady),  32'd0);
        chk("rst_vld",  32'(bus.RespValid), 32'd0);
        chk("rst_res",  bus.RespResult,     32'd0);
        chk("rst_zero", 32'(bus.RespZero),  32'd0);
        chk("rst_srca", SrcA,               32'd0);
        chk("rst_srcb", SrcB,               32'd0);
        chk("rst_ctrl", 32'(ALUControl),    32'd0);
        tick();
        bus.ReqValid = 2'b00;
        tick();
        reset_n = 1'b1;
        tick();

        // Basic ADD on requester 0; LastGrant becomes 0.
        run_single("t1_add", 1'b0, 32'h11, 32'h22, ALU_ADD, 32'h33, 1'b0);

        // Requester 1 SUB to zero under long backpressure; stray ready from 0 ignored.
        set_req(1'b1, 32'h5, 32'h5, ALU_SUB);
        bus.ReqValid = 2'b10;
        #1;
        chk("t3_rdy", 32'(bus.ReqReady), 32'(2'b10));
        tick();
        bus.ReqValid = 2'b11;
        set_req(1'b0, 32'h7, 32'h1, ALU_ADD);
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.RespReady = (i % 2 == 0) ? 2'b01 : 2'b00;
            chk("t3_hold_vld",  32'(bus.RespValid), 32'(2'b10));
            chk("t3_hold_res",  bus.RespResult,     32'd0);
            chk("t3_hold_zero", 32'(bus.RespZero),  32'd1);
            chk("t3_hold_rdy",  32'(bus.ReqReady),  32'd0);
            chk("t3_hold_srca", SrcA,               32'h5);
            tick();
        end
        chk("t6_ignored_vld", 32'(bus.RespValid), 32'(2'b10));
        bus.ReqValid  = 2'b00;
        bus.RespReady = 2'b10;
        tick();
        bus.RespReady = 2'b00;
        chk("t3_done_vld", 32'(bus.RespValid), 32'd0);

        // Contention after requester 1 was served last: requester 0 wins.
        set_req(1'b0, 32'hFF, 32'hF0, ALU_SUB);
        set_req(1'b1, 32'hFF, 32'hF0F, ALU_OR);
        bus.ReqValid = 2'b11;
        #1;
        chk("t2_first_rdy", 32'(bus.ReqReady), 32'(2'b01));
        tick();
        bus.ReqValid = 2'b10;
        chk("t2_exec_rdy", 32'(bus.ReqReady), 32'd0);
        tick();
        chk("t2_r0_vld", 32'(bus.RespValid), 32'(2'b01));
        chk("t2_r0_res", bus.RespResult,     32'h0F);
        // Requester 0 re-requests at once: contention again, now requester 1 first.
        bus.RespReady = 2'b01;
        set_req(1'b0, 32'hF0F0, 32'hFF00, ALU_AND);
        bus.ReqValid = 2'b11;
        tick();
        bus.RespReady = 2'b00;
        chk("t2_second_rdy", 32'(bus.ReqReady), 32'(2'b10));
        tick();
        bus.ReqValid = 2'b01;
        tick();
        chk("t2_r1_vld",  32'(bus.RespValid), 32'(2'b10));
        chk("t2_r1_res",  bus.RespResult,     32'hFFF);
        chk("t2_r1_zero", 32'(bus.RespZero),  32'd0);
        bus.RespReady = 2'b10;
        tick();
        bus.RespReady = 2'b00;
        chk("t2_third_rdy", 32'(bus.ReqReady), 32'(2'b01));
        tick();
        bus.ReqValid = 2'b00;
        tick();
        chk("t2_r0b_vld", 32'(bus.RespValid), 32'(2'b01));
        chk("t2_r0b_res", bus.RespResult,     32'hF000);
        bus.RespReady = 2'b01;
        tick();
        bus.RespReady = 2'b00;

        // Signed compare and pass-through of operand B.
        run_single("t4_slt",  1'b0, 32'hFFFFFFFF, 32'h1, ALU_SLT, 32'h1, 1'b0);
        run_single("t4_pass", 1'b0, 32'hFF, 32'hF0F0F0F0, ALU_PASS, 32'hF0F0F0F0, 1'b0);

        // Reset in the middle of EXEC drops the operation.
        set_req(1'b0, 32'h7, 32'h3, ALU_SUB);
        bus.ReqValid = 2'b01;
        tick();
        chk("t5_exec_rdy", 32'(bus.ReqReady), 32'd0);
        bus.ReqValid = 2'b00;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_vld",  32'(bus.RespValid), 32'd0);
        chk("t5_rst_res",  bus.RespResult,     32'd0);
        chk("t5_rst_srca", SrcA,               32'd0);
        chk("t5_rst_ctrl", 32'(ALUControl),    32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_resp", 32'(bus.RespValid), 32'd0);
        end
        run_single("t5_add", 1'b0, 32'h1, 32'h1, ALU_ADD, 32'h2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
